bcd_conv_arbiter: RTL and testbench

//   Shares one bin2bcd converter between NREQ requesters (display channels, debug

---
 rtl/bcd_conv_arbiter.sv | 151 +++++++++++++++
 tb/tb_bcd_conv_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : bcd_conv_arbiter
// Brief   : Round-robin sharing of one bin2bcd converter among NREQ requesters.
//           Optional WAIT timeout enabled by defining BCD_ARB_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module bcd_conv_arbiter #(
  parameter int N       = 7,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*N-1:0]        req_bin,
  output logic [NREQ-1:0]          gnt,
  output logic                     rsp_valid,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [15:0]              rsp_bcd,
  output logic                     rsp_err,
  output logic                     busy,
  output logic                     conv_start,
  output logic [N-1:0]             conv_bin,
  input  logic [15:0]              conv_bcd,
  input  logic                     conv_done
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_SETTLE = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_rr_ptr;
  logic [IDW-1:0]   r_id;
  logic [IDW-1:0]   w_winner;
  logic [IDW-1:0]   w_idx;
  logic [IDW-1:0]   w_next_ptr;
  logic             w_found;
  logic [N-1:0]     w_ops [NREQ];

  generate
    for (genvar g = 0; g < NREQ; g++) begin : g_ops
      assign w_ops[g] = req_bin[g*N +: N];
    end
  endgenerate

  // Scan downward so the last hit is the one closest above rr_ptr.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_idx = IDW'((int'(r_rr_ptr) + i) % NREQ);
      if (req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_next_ptr = (r_id == IDW'(NREQ - 1)) ? '0 : r_id + 1'b1;

`ifdef BCD_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] r_cnt;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_id       <= '0;
      gnt        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_bcd    <= '0;
      busy       <= 1'b0;
      conv_start <= 1'b0;
      conv_bin   <= '0;
`ifdef BCD_ARB_TIMEOUT_EN
      rsp_err    <= 1'b0;
      r_cnt      <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_id       <= w_winner;
            conv_bin   <= w_ops[w_winner];
            gnt        <= {{(NREQ-1){1'b0}}, 1'b1} << w_winner;
            conv_start <= 1'b1;
            busy       <= 1'b1;
            r_state    <= S_START;
          end
        end
        S_START: begin
          gnt        <= '0;
          conv_start <= 1'b0;
          r_state    <= S_SETTLE;
        end
        // One dead cycle so a level done left over from the last job is not taken.
        S_SETTLE: begin
`ifdef BCD_ARB_TIMEOUT_EN
          r_cnt   <= '0;
`endif
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (conv_done) begin
            rsp_bcd   <= conv_bcd;
            rsp_id    <= r_id;
            rsp_valid <= 1'b1;
`ifdef BCD_ARB_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            r_state   <= S_RESP;
          end
`ifdef BCD_ARB_TIMEOUT_EN
          else if (r_cnt == CW'(TIMEOUT - 1)) begin
            rsp_bcd   <= 16'hFFFF;
            rsp_id    <= r_id;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            r_state   <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          r_rr_ptr  <= w_next_ptr;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_bcd_conv_arbiter
// Brief   : Directed self-checking bench for bcd_conv_arbiter with a converter model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bcd_conv_arbiter;

  localparam int N    = 7;
  localparam int NREQ = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [27:0] req_bin = '0;
  logic [3:0]  gnt;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_bcd;
  logic        rsp_err;
  logic        busy;
  logic        conv_start;
  logic [6:0]  conv_bin;
  logic [15:0] conv_bcd;
  logic        conv_done;

  bcd_conv_arbiter #(.N(N), .NREQ(NREQ), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .req(req), .req_bin(req_bin), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_bcd(rsp_bcd), .rsp_err(rsp_err),
    .busy(busy), .conv_start(conv_start), .conv_bin(conv_bin),
    .conv_bcd(conv_bcd), .conv_done(conv_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Converter model: result appears m_lat+2 cycles after start; level or pulse done.
  int         m_lat   = 0;
  bit         m_level = 1'b0;
  bit         m_hang  = 1'b0;
  logic       m_start_d, m_run, m_done;
  int         m_cnt;
  logic [6:0] m_bin;
  logic [15:0] m_bcd;

  function automatic logic [15:0] to_bcd(input logic [6:0] v);
    int x;
    x = int'(v);
    return {4'd0, 4'(x / 100), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_start_d <= 1'b0; m_run <= 1'b0; m_done <= 1'b0;
      m_cnt <= 0; m_bin <= '0; m_bcd <= '0;
    end else begin
      m_start_d <= conv_start;
      if (conv_start) m_bin <= conv_bin;
      if (!m_level) m_done <= 1'b0;
      if (m_start_d) begin
        m_cnt <= m_lat;
        m_run <= 1'b1;
        if (m_level) m_done <= 1'b0;
      end else if (m_run) begin
        if (m_cnt == 0) begin
          m_run <= 1'b0;
          if (!m_hang) begin
            m_done <= 1'b1;
            m_bcd  <= to_bcd(m_bin);
          end
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end
  assign conv_done = m_done;
  assign conv_bcd  = m_bcd;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] bcd;
    logic        err;
    int          cyc;
  } rsp_t;
  rsp_t       rq[$];
  logic [3:0] gq[$];
  int         gc[$];

  always @(negedge clk) begin
    if (rst) begin
      if (gnt != 4'b0) begin
        gq.push_back(gnt);
        gc.push_back(cyc);
      end
      if (rsp_valid) rq.push_back('{rsp_id, rsp_bcd, rsp_err, cyc});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bin(input int i, input logic [6:0] v);
    req_bin[i*N +: N] = v;
  endtask

  task automatic apply_reset();
    rst = 1'b0; req = '0; m_hang = 1'b0; m_level = 1'b0; m_lat = 0;
    repeat (2) tick();
    gq.delete(); gc.delete(); rq.delete();
    rst = 1'b1;
    tick();
  endtask

  task automatic wait_rsp(input int want);
    for (int k = 0; k < 200 && rq.size() < want; k++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    total++;
    if ({gnt, rsp_valid, busy, conv_start, rsp_err, rsp_id, rsp_bcd, conv_bin} !== 32'd0) begin
      bad++;
      $display("FAIL reset_outputs: got gnt=%b v=%b busy=%b st=%b err=%b id=%0d bcd=%h bin=%0d want all 0",
               gnt, rsp_valid, busy, conv_start, rsp_err, rsp_id, rsp_bcd, conv_bin);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    set_bin(0, 7'd53);
    req = 4'b0001;
    tick();
    total++;
    if ({gnt, busy, conv_start} !== 6'b0001_1_1) begin
      bad++; $display("FAIL single_gnt: got gnt=%b busy=%b start=%b want 0001 1 1", gnt, busy, conv_start);
    end
    req = '0;
    repeat (4) tick();
    total++;
    if ({rsp_valid, rsp_id, rsp_err} !== 4'b1_00_0) begin
      bad++; $display("FAIL single_rsp: got v=%b id=%0d err=%b want 1 0 0", rsp_valid, rsp_id, rsp_err);
    end
    total++;
    if (rsp_bcd !== 16'h0053) begin
      bad++; $display("FAIL single_bcd: got %h want 0053", rsp_bcd);
    end
    tick();
    total++;
    if ({rsp_valid, busy} !== 2'b00) begin
      bad++; $display("FAIL single_idle: got v=%b busy=%b want 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_all_pending();
    logic [3:0]  eg[4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [15:0] eb[4] = '{16'h0007, 16'h0053, 16'h0099, 16'h0120};
    int n = 0;
    apply_reset();
    set_bin(0, 7'd7); set_bin(1, 7'd53); set_bin(2, 7'd99); set_bin(3, 7'd120);
    req = 4'b1111;
    for (int k = 0; k < 200 && n < 4; k++) begin
      tick();
      if (gnt != 4'b0) n++;
      if (gnt == 4'b1000) req = '0;
    end
    req = '0;
    wait_rsp(4);
    total++;
    if (gq.size() != 4 || rq.size() != 4) begin
      bad++; $display("FAIL rr_count: got grants=%0d rsps=%0d want 4 4", gq.size(), rq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (gq[i] !== eg[i] || rq[i].id !== 2'(i) || rq[i].bcd !== eb[i]) begin
          bad++; $display("FAIL rr_job%0d: got gnt=%b id=%0d bcd=%h want %b %0d %h",
                          i, gq[i], rq[i].id, rq[i].bcd, eg[i], i, eb[i]);
        end
      end
      total++;
      if (gc[3] - gc[0] != 18) begin
        bad++; $display("FAIL back_to_back: got grant span=%0d want 18", gc[3] - gc[0]);
      end
    end
  endtask

  task automatic test_fairness();
    logic [3:0]  eg[3] = '{4'b0001, 4'b0100, 4'b0001};
    logic [1:0]  ei[3] = '{2'd0, 2'd2, 2'd0};
    logic [15:0] eb[3] = '{16'h0011, 16'h0042, 16'h0011};
    int n = 0;
    apply_reset();
    set_bin(0, 7'd11); set_bin(2, 7'd42);
    req = 4'b0001;
    for (int k = 0; k < 200 && n < 3; k++) begin
      tick();
      if (gnt != 4'b0) begin
        n++;
        if (n == 1) req[2] = 1'b1;
        if (n == 3) req = '0;
      end
    end
    req = '0;
    wait_rsp(3);
    total++;
    if (gq.size() != 3 || rq.size() != 3) begin
      bad++; $display("FAIL fair_count: got grants=%0d rsps=%0d want 3 3", gq.size(), rq.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (gq[i] !== eg[i] || rq[i].id !== ei[i] || rq[i].bcd !== eb[i]) begin
          bad++; $display("FAIL fair_job%0d: got gnt=%b id=%0d bcd=%h want %b %0d %h",
                          i, gq[i], rq[i].id, rq[i].bcd, eg[i], ei[i], eb[i]);
        end
      end
    end
  endtask

  task automatic test_reset_in_wait();
    apply_reset();
    m_hang = 1'b1;
    set_bin(2, 7'd77);
    req = 4'b0100;
    tick();
    req = '0;
    repeat (3) tick();
    total++;
    if ({busy, conv_bin} !== {1'b1, 7'd77}) begin
      bad++; $display("FAIL wait_pre: got busy=%b bin=%0d want 1 77", busy, conv_bin);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if ({gnt, rsp_valid, busy, conv_start, rsp_err, rsp_id, rsp_bcd, conv_bin} !== 32'd0) begin
      bad++; $display("FAIL async_reset: got gnt=%b v=%b busy=%b bcd=%h bin=%0d want all 0",
                      gnt, rsp_valid, busy, rsp_bcd, conv_bin);
    end
    repeat (2) tick();
    m_hang = 1'b0;
    rst = 1'b1;
    tick();
    total++;
    if (rq.size() != 0) begin
      bad++; $display("FAIL dropped_job: got rsps=%0d want 0", rq.size());
    end
    set_bin(1, 7'd99);
    req = 4'b0010;
    tick();
    req = '0;
    wait_rsp(1);
    total++;
    if (rq.size() != 1) begin
      bad++; $display("FAIL post_reset_rsp: got rsps=%0d want 1", rq.size());
    end else if (rq[0].id !== 2'd1 || rq[0].bcd !== 16'h0099) begin
      bad++; $display("FAIL post_reset_rsp: got id=%0d bcd=%h want 1 0099", rq[0].id, rq[0].bcd);
    end
  endtask

  task automatic test_stale_done();
    apply_reset();
    m_level = 1'b1;
    m_lat   = 2;
    set_bin(0, 7'd25);
    req = 4'b0001;
    tick();
    req = '0;
    wait_rsp(1);
    repeat (5) tick();
    total++;
    if (rq.size() != 1 || conv_done !== 1'b1) begin
      bad++; $display("FAIL idle_done_ignored: got rsps=%0d done=%b want 1 1", rq.size(), conv_done);
    end else begin
      total++;
      if (rq[0].bcd !== 16'h0025) begin
        bad++; $display("FAIL level_first: got %h want 0025", rq[0].bcd);
      end
    end
    set_bin(1, 7'd88);
    req = 4'b0010;
    tick();
    req = '0;
    wait_rsp(2);
    total++;
    if (rq.size() != 2) begin
      bad++; $display("FAIL stale_mask: got rsps=%0d want 2", rq.size());
    end else if (rq[1].id !== 2'd1 || rq[1].bcd !== 16'h0088) begin
      bad++; $display("FAIL stale_mask: got id=%0d bcd=%h want 1 0088", rq[1].id, rq[1].bcd);
    end
  endtask

`ifdef BCD_ARB_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset();
    m_hang = 1'b1;
    set_bin(0, 7'd5);
    req = 4'b0001;
    tick();
    req = '0;
    wait_rsp(1);
    m_hang = 1'b0;
    total++;
    if (rq.size() != 1 || gq.size() != 1) begin
      bad++; $display("FAIL timeout_rsp: got rsps=%0d grants=%0d want 1 1", rq.size(), gq.size());
    end else if (rq[0].err !== 1'b1 || rq[0].bcd !== 16'hFFFF || rq[0].cyc - gc[0] != 66) begin
      bad++; $display("FAIL timeout_rsp: got err=%b bcd=%h gap=%0d want 1 ffff 66",
                      rq[0].err, rq[0].bcd, rq[0].cyc - gc[0]);
    end
    set_bin(3, 7'd120);
    req = 4'b1000;
    tick();
    req = '0;
    wait_rsp(2);
    total++;
    if (rq.size() != 2) begin
      bad++; $display("FAIL timeout_next: got rsps=%0d want 2", rq.size());
    end else if (rq[1].err !== 1'b0 || rq[1].bcd !== 16'h0120 || rq[1].id !== 2'd3) begin
      bad++; $display("FAIL timeout_next: got err=%b bcd=%h id=%0d want 0 0120 3",
                      rq[1].err, rq[1].bcd, rq[1].id);
    end
  endtask
`else
  task automatic test_timeout();
    apply_reset();
    m_hang = 1'b1;
    set_bin(0, 7'd5);
    req = 4'b0001;
    tick();
    req = '0;
    repeat (100) tick();
    total++;
    if (busy !== 1'b1 || rq.size() != 0 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL wait_holds: got busy=%b rsps=%0d err=%b want 1 0 0", busy, rq.size(), rsp_err);
    end
    apply_reset();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_all_pending();
    test_fairness();
    test_reset_in_wait();
    test_stale_done();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
